// File: rtl/parity_using_assign_core.sv
`default_nettype none
// ============================================================================
// Module   : parity_using_assign_core
// Function : Combinational parity generator with registered, valid-qualified
//            parity, received-parity mismatch flag and saturating error count.
// Revision : 1.0 - initial release
// ============================================================================
module parity_using_assign_core #(
    parameter int WIDTH = 8,
    parameter int ODD   = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    output logic             parity_out,
    input  logic             in_valid,
    input  logic             parity_in,
    input  logic             clr_count,
    output logic             parity_q,
    output logic             out_valid,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);

    localparam logic             c_odd     = (ODD != 0);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic             w_mismatch;
    logic             r_parity_q;
    logic             r_out_valid;
    logic             r_err;
    logic [CNT_W-1:0] r_err_count;

    // Plain reduction XOR so X/Z on any data bit reaches the output unmasked.
    assign parity_out = (^data_in) ^ c_odd;
    assign w_mismatch = parity_out ^ parity_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity_q  <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            r_err       <= in_valid & w_mismatch;
            if (in_valid) begin
                r_parity_q <= parity_out;
            end
        end
    end

    // Clear wins over a coincident increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (clr_count) begin
            r_err_count <= '0;
        end else if (in_valid && w_mismatch && (r_err_count != c_cnt_max)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign parity_q  = r_parity_q;
    assign out_valid = r_out_valid;
    assign err       = r_err;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_parity_using_assign_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_using_assign_core
// Function : Directed, table-driven self-checking bench for the parity core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parity_using_assign_core;

    typedef struct {
        logic [7:0] data;
        logic       exp_even;
        logic       exp_odd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data_in;
    logic        in_valid;
    logic        parity_in;
    logic        clr_count;

    logic        p_out0, pq0, ov0, err0;
    logic [15:0] cnt0;
    logic        p_out1, pq1, ov1, err1;
    logic [15:0] cnt1;
    logic        p_out2, pq2, ov2, err2;
    logic [1:0]  cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    parity_using_assign_core #(.WIDTH(8), .ODD(0), .CNT_W(16)) u_even (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .parity_out(p_out0),
        .in_valid(in_valid), .parity_in(parity_in), .clr_count(clr_count),
        .parity_q(pq0), .out_valid(ov0), .err(err0), .err_count(cnt0)
    );

    parity_using_assign_core #(.WIDTH(8), .ODD(1), .CNT_W(16)) u_odd (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .parity_out(p_out1),
        .in_valid(in_valid), .parity_in(parity_in), .clr_count(clr_count),
        .parity_q(pq1), .out_valid(ov1), .err(err1), .err_count(cnt1)
    );

    parity_using_assign_core #(.WIDTH(8), .ODD(0), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .parity_out(p_out2),
        .in_valid(in_valid), .parity_in(parity_in), .clr_count(clr_count),
        .parity_q(pq2), .out_valid(ov2), .err(err2), .err_count(cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'h00, 1'b0, 1'b1};
        vecs[1] = '{8'h01, 1'b1, 1'b0};
        vecs[2] = '{8'h03, 1'b0, 1'b1};
        vecs[3] = '{8'hAA, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 1'b0, 1'b1};
        vecs[5] = '{8'h07, 1'b1, 1'b0};

        rst_n     = 1'b0;
        data_in   = 8'h00;
        in_valid  = 1'b0;
        parity_in = 1'b0;
        clr_count = 1'b0;

        // Combinational parity while held in reset
        for (int i = 0; i < 6; i++) begin
            data_in = vecs[i].data;
            #10;
            chk($sformatf("parity_even[%0d]", i), {31'd0, p_out0}, {31'd0, vecs[i].exp_even});
            chk($sformatf("parity_odd[%0d]", i),  {31'd0, p_out1}, {31'd0, vecs[i].exp_odd});
        end

        chk("rst_parity_q",  {31'd0, pq0},  32'd0);
        chk("rst_out_valid", {31'd0, ov0},  32'd0);
        chk("rst_err",       {31'd0, err0}, 32'd0);
        chk("rst_err_count", {16'd0, cnt0}, 32'd0);

        step();
        rst_n = 1'b1;

        // Registered path: matching parity
        in_valid = 1'b1; data_in = 8'h01; parity_in = 1'b1;
        step();
        chk("reg_parity_q",  {31'd0, pq0},  32'd1);
        chk("reg_out_valid", {31'd0, ov0},  32'd1);
        chk("reg_err",       {31'd0, err0}, 32'd0);
        chk("reg_err_count", {16'd0, cnt0}, 32'd0);
        chk("reg_odd_err",   {31'd0, err1}, 32'd1);
        in_valid = 1'b0; data_in = 8'h00;
        step();
        chk("idle_out_valid", {31'd0, ov0}, 32'd0);
        chk("idle_parity_q",  {31'd0, pq0}, 32'd1);

        // Five consecutive mismatches: 16-bit count climbs, 2-bit count saturates
        in_valid = 1'b1; data_in = 8'h03; parity_in = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("mm_err[%0d]", k),      {31'd0, err0}, 32'd1);
            chk($sformatf("mm_parity_q[%0d]", k), {31'd0, pq0},  32'd0);
            chk($sformatf("mm_cnt[%0d]", k),      {16'd0, cnt0}, k);
            chk($sformatf("sat_cnt[%0d]", k),     {30'd0, cnt2}, (k > 3) ? 32'd3 : k);
        end

        // Clear beats a simultaneous mismatch
        clr_count = 1'b1;
        step();
        chk("clr_cnt",     {16'd0, cnt0}, 32'd0);
        chk("clr_sat_cnt", {30'd0, cnt2}, 32'd0);
        chk("clr_err",     {31'd0, err0}, 32'd1);
        clr_count = 1'b0;

        step();
        step();
        chk("pre_rst_cnt",   {16'd0, cnt0}, 32'd2);
        chk("pre_rst_valid", {31'd0, ov0},  32'd1);

        // Asynchronous reset between edges
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_parity_q",  {31'd0, pq0},  32'd0);
        chk("arst_out_valid", {31'd0, ov0},  32'd0);
        chk("arst_err",       {31'd0, err0}, 32'd0);
        chk("arst_cnt",       {16'd0, cnt0}, 32'd0);
        chk("arst_sat_cnt",   {30'd0, cnt2}, 32'd0);
        data_in = 8'h01;
        #1;
        chk("arst_parity_track", {31'd0, p_out0}, 32'd1);
        data_in = 8'h03;

        #2;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();
        chk("rel_out_valid", {31'd0, ov0},  32'd0);
        chk("rel_cnt",       {16'd0, cnt0}, 32'd0);
        in_valid = 1'b1;
        step();
        chk("rel2_out_valid", {31'd0, ov0},  32'd1);
        chk("rel2_cnt",       {16'd0, cnt0}, 32'd1);
        in_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/parity_using_assign_core.md
# parity_using_assign_core

Parity generator/checker for a parallel data word. It produces a zero-latency combinational parity bit for `data_in`. It also provides a registered, valid-qualified copy of that parity, a received-parity mismatch flag, and a saturating error counter. It sits on datapath boundaries: generating parity on transmit, and checking received parity on receive.

## Interface
Parameters:
- `WIDTH`, 8, data word width in bits (≥1).
- `ODD`, 0, parity sense. 0 selects even parity (XOR reduction of `data_in`). 1 selects odd parity (inverted XOR reduction).
- `CNT_W`, 16, error counter width.

Ports:
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_in` in `WIDTH`: data word.
- `parity_out` out 1: combinational parity of `data_in`.
- `in_valid` in 1: qualifies `data_in` / `parity_in` for the registered path.
- `parity_in` in 1: received parity bit to check against `data_in`.
- `clr_count` in 1: synchronous clear of `err_count`.
- `parity_q` out 1: registered parity of the last valid word.
- `out_valid` out 1: registered `in_valid`.
- `err` out 1: registered mismatch flag.
- `err_count` out `CNT_W`: saturating count of mismatches.

## Operation
- `parity_out` = XOR of all `data_in` bits, XOR `ODD`.
  - Purely combinational, with no dependence on `clk` or `rst_n`.
  - Valid whenever `data_in` is stable, including during reset.
- `mismatch` (internal) = `parity_out` XOR `parity_in`.
- On each rising `clk` edge with `in_valid`=1:
  - `parity_q` <= `parity_out`.
  - `err` <= `mismatch`.
  - `out_valid` <= 1.
- On each rising `clk` edge with `in_valid`=0:
  - `out_valid` <= 0.
  - `err` <= 0.
  - `parity_q` holds its last value.
- `err_count`:
  - `clr_count`=1 sets it to 0. Clear has priority over a simultaneous increment.
  - Otherwise it increments by 1 when `in_valid`=1 and `mismatch`=1.
  - It saturates at all-ones (2^`CNT_W`−1) and never wraps.
- X/Z on `data_in` bits propagates to `parity_out`. No masking is applied.

## Timing
- `parity_out`: zero-cycle latency, combinational path only.
- `parity_q`, `err`, `out_valid`, `err_count`: one-cycle latency from the sampling edge.
- Throughput is one word per cycle. There is no backpressure and no handshake beyond `in_valid`.
- Reset:
  - `rst_n` low immediately forces `parity_q`=0, `out_valid`=0, `err`=0, `err_count`=0, independent of `clk`.
  - Release is synchronous to the next rising edge. The first sample occurs on the first edge with `rst_n`=1.
- Reset asserted mid-stream discards the in-flight word. `out_valid` is 0 on the first edge after release unless `in_valid`=1 at that edge.

## Test plan
- Combinational, `ODD`=0, no clock: `data_in`=00000000 -> `parity_out`=0; 00000001 -> 1; 00000011 -> 0; 10101010 -> 0; 11111111 -> 0. Each value is checked 10 time units after it is applied.
- `ODD`=1: `data_in`=00000000 -> `parity_out`=1; 00000111 -> 0.
- Registered path: `in_valid`=1, `data_in`=0x01, `parity_in`=1 for one cycle -> next cycle `parity_q`=1, `out_valid`=1, `err`=0, `err_count`=0. Then `in_valid`=0 -> `out_valid`=0, `parity_q` stays 1.
- Error path: `data_in`=0x03, `parity_in`=1, `in_valid`=1 for 3 cycles -> `err`=1 on each following cycle and `err_count`=3. Asserting `clr_count` together with a further mismatch -> `err_count`=0.
- Saturation with `CNT_W`=2: 5 consecutive mismatches -> `err_count` reaches 3 and stays 3.
- Async reset: drive `rst_n` low between clock edges while `err_count`=2 and `out_valid`=1 -> all registered outputs read 0 before the next edge. `parity_out` continues to track `data_in` throughout.
